seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Parametrised serial bit-pattern detector; successor to the fixed 1010 Mealy detector.
//  Pattern length, reset pattern, overlap mode and Mealy/Moore output timing are set by parameters.
//  Pattern is reloadable at runtime. A saturating match counter is included.
//  Sits between a serial input stream and the status/interrupt logic.
// PARAMETERS
//  PAT_LEN   4         pattern length in bits, legal range 2..32
//  PATTERN   4'b1010   pattern loaded at reset; MSB is the oldest bit received
//  OVERLAP   1         1 = overlapping matches counted; 0 = history restarts after each match
//  MOORE     0         0 = Mealy (combinational out, same cycle as last bit); 1 = Moore (registered, +1 cycle)
//  CNT_W     8         match counter width
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous reset, active-high
//  in         in   1        serial data bit
//  in_valid   in   1        in is sampled only when 1; otherwise all state holds
//  pat_load   in   1        load pat_in as the new pattern at the next clock edge
//  pat_in     in   PAT_LEN  new pattern, MSB oldest
//  cnt_clr    in   1        synchronous clear of match_cnt
//  out        out  1        detect pulse
//  match_cnt  out  CNT_W    number of detections, saturating
//  cnt_sat    out  1        high while match_cnt is all-ones
// BEHAVIOUR
//  - Reset (async): pattern<=PATTERN, hist<=0, fill<=0, out_q<=0, match_cnt<=0.
//    out=0 and cnt_sat=0 while rst is high.
//  - hist: PAT_LEN-1 bit shift register of past bits. fill: 0..PAT_LEN-1 count of valid history bits.
//  - hit = in_valid & (fill==PAT_LEN-1) & ({hist,in}==pattern). Combinational.
//  - On a clock edge with in_valid=1: hist<={hist[PAT_LEN-3:0],in}.
//    If hit & !OVERLAP, fill<=0. Otherwise fill<=min(fill+1,PAT_LEN-1).
//  - in_valid=0: hist and fill hold. hit=0. Gaps do not break a partial match.
//  - Mealy: out=hit. Moore: out_q<=hit, out=out_q, so the pulse is 1 cycle after the last bit.
//  - pat_load=1: pattern<=pat_in, hist<=0, fill<=0 at the edge. The bit sampled in that cycle is discarded.
//    A hit in that same cycle is still reported and counted, because it was evaluated against the old pattern.
//  - match_cnt: increments at the edge where hit=1. Holds at all-ones (no wrap). cnt_sat=&match_cnt.
//    cnt_clr and hit in the same cycle: clear wins, match_cnt<=0.
//  - No detection is possible until PAT_LEN valid bits have arrived after reset, reload, or a non-overlap match.
//  - Reset asserted mid-stream discards all partial history.
//    In Moore mode, a pending out_q pulse is dropped.
// STRUCTURE
//  - Package seq_det_pkg: MODE_MEALY/MODE_MOORE, OVL_ON/OVL_OFF constants; function min_sat for fill update.
//  - Sub-module sat_counter #(W): en, clr (clr priority), cnt, sat.
//    Instantiated once for match_cnt and reusable elsewhere.
//  - Top level contains pattern register, hist/fill, hit compare, and the Moore output register.
// TESTING
//  1. Default params, after rst: in=1,0,1,0,1,0,1,0 valid every cycle
//     -> out on bits 4, 6 and 8 (same cycle, Mealy); match_cnt=3.
//  2. OVERLAP=0, same stream -> out on bits 4 and 8 only; match_cnt=2.
//  3. MOORE=1, stream 1,0,1,0 -> out high exactly 1 cycle after bit 4, width 1 cycle.
//  4. in_valid=0 for 3 cycles between bits 2 and 3 of 1010 -> still detected on bit 4.
//     Stream 1,1,0 then 0 -> no out.
//  5. pat_load with pat_in=4'b1101 mid-stream, then send 1,1,0,1,1,0,1
//     -> out on bits 4 and 7; old 1010 no longer matches.
//  6. CNT_W=2: 5 matches -> match_cnt sticks at 3 with cnt_sat=1.
//     cnt_clr coincident with a hit -> match_cnt=0.
//     rst asserted asynchronously mid-pattern -> out=0 and match_cnt=0 immediately.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised sequence detector.
package seq_det_pkg;

  localparam bit MODE_MEALY = 1'b0;
  localparam bit MODE_MOORE = 1'b1;
  localparam bit OVL_OFF    = 1'b0;
  localparam bit OVL_ON     = 1'b1;

  // Saturating upper bound used when advancing the history fill level.
  function automatic int unsigned min_sat(input int unsigned val, input int unsigned lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  assign sat = &cnt;

  // Count enabled events, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with runtime-reloadable pattern,
// selectable overlap handling, Mealy/Moore output timing and a match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
  parameter bit               OVERLAP = OVL_ON,
  parameter bit               MOORE   = MODE_MEALY,
  parameter int               CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               in_valid,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               cnt_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  localparam int               FILL_W    = $clog2(PAT_LEN);
  localparam int unsigned      FILL_MAX  = PAT_LEN - 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] pattern;
  logic [PAT_LEN-2:0] hist;
  logic [FILL_W-1:0]  fill;
  logic [PAT_LEN-1:0] window;
  logic               hit;

  // The candidate word is the stored history with the current bit appended as the newest.
  assign window = {hist, in};
  assign hit    = in_valid && (fill == FILL_FULL) && (window == pattern);

  // Pattern register plus history/fill tracking; a reload wipes history and drops the current bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern <= PATTERN;
      hist    <= '0;
      fill    <= '0;
    end else if (pat_load) begin
      pattern <= pat_in;
      hist    <= '0;
      fill    <= '0;
    end else if (in_valid) begin
      hist <= window[PAT_LEN-2:0];
      if (hit && (OVERLAP == OVL_OFF)) begin
        fill <= '0;
      end else begin
        fill <= FILL_W'(min_sat(32'(fill) + 32'd1, FILL_MAX));
      end
    end
  end

  generate
    if (MOORE == MODE_MOORE) begin : g_moore
      logic out_q;

      // Registered detect pulse, one cycle after the final pattern bit.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_q <= 1'b0;
        end else begin
          out_q <= hit;
        end
      end

      assign out = out_q;
    end else begin : g_mealy
      assign out = hit;
    end
  endgenerate

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .en  (hit),
    .clr (cnt_clr),
    .cnt (match_cnt),
    .sat (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: four instances (default, non-overlap, Moore,
// 2-bit counter) share one stimulus stream and are checked against a queue model.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       in;
  logic       in_valid;
  logic       pat_load;
  logic [3:0] pat_in;
  logic       cnt_clr;

  logic [3:0] outs;
  logic [3:0] sats;
  logic [7:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;

  int total = 0;
  int bad   = 0;

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  seq_detector_param u0 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .out(outs[0]), .match_cnt(cnt0), .cnt_sat(sats[0])
  );

  seq_detector_param #(.OVERLAP(1'b0)) u1 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .out(outs[1]), .match_cnt(cnt1), .cnt_sat(sats[1])
  );

  seq_detector_param #(.MOORE(1'b1)) u2 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .out(outs[2]), .match_cnt(cnt2), .cnt_sat(sats[2])
  );

  seq_detector_param #(.CNT_W(2)) u3 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .out(outs[3]), .match_cnt(cnt3), .cnt_sat(sats[3])
  );

  // Reference model: bits received since the last restart, newest at the back.
  bit         mq[4][$];
  logic [3:0] mpat[4];
  int         mcnt[4];
  bit         mout_q[4];

  function automatic bit ovl_of(int k);
    return k != 1;
  endfunction

  function automatic bit moore_of(int k);
    return k == 2;
  endfunction

  function automatic int cmax_of(int k);
    return (k == 3) ? 3 : 255;
  endfunction

  function automatic logic [7:0] cnt_of(int k);
    case (k)
      0:       return cnt0;
      1:       return cnt1;
      2:       return cnt2;
      default: return {6'b0, cnt3};
    endcase
  endfunction

  function automatic bit model_hit(int k, bit b, bit v);
    int s;
    logic [3:0] w;
    s = mq[k].size();
    if (!v || s < 3) return 1'b0;
    w = {mq[k][s-3], mq[k][s-2], mq[k][s-1], b};
    return w == mpat[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      mpat[k]   = 4'b1010;
      mcnt[k]   = 0;
      mout_q[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in = 1'b0; in_valid = 1'b0; pat_load = 1'b0; pat_in = 4'b0; cnt_clr = 1'b0;
    @(negedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One clock cycle: drive inputs, sample outputs at the falling edge, advance the model after the rising edge.
  task automatic cycle(input bit b, input bit v, input bit ld, input logic [3:0] pin, input bit clr,
                       output logic [3:0] exp_o, output logic [3:0] obs_o);
    bit h[4];
    in = b; in_valid = v; pat_load = ld; pat_in = pin; cnt_clr = clr;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      h[k]     = model_hit(k, b, v);
      exp_o[k] = moore_of(k) ? mout_q[k] : h[k];
    end
    obs_o = outs;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (clr) mcnt[k] = 0;
      else if (h[k] && mcnt[k] < cmax_of(k)) mcnt[k]++;
      mout_q[k] = h[k];
      if (ld) begin
        mq[k].delete();
        mpat[k] = pin;
      end else if (v) begin
        mq[k].push_back(b);
        if (mq[k].size() > 3) void'(mq[k].pop_front());
        if (h[k] && !ovl_of(k)) mq[k].delete();
      end
    end
    in_valid = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
  endtask

  // Run a string of bits with a parallel validity string; returns per-instance out masks (bit i = cycle i).
  task automatic stream(input string bits, input string vld,
                        output logic [15:0] m0, output logic [15:0] m1,
                        output logic [15:0] m2, output int mism);
    logic [3:0] e, o;
    m0 = '0; m1 = '0; m2 = '0; mism = 0;
    for (int i = 0; i < bits.len(); i++) begin
      cycle(bits[i] == "1", vld[i] == "1", 1'b0, 4'b0, 1'b0, e, o);
      m0[i] = o[0]; m1[i] = o[1]; m2[i] = o[2];
      if (o !== e) mism++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in = 1'b0; in_valid = 1'b0; pat_load = 1'b0; pat_in = 4'b0; cnt_clr = 1'b0;
    model_reset();
    #2;
    total++;
    if (outs !== 4'b0) begin bad++; $display("[TB] FAIL reset_out: got %b expected 0000", outs); end
    total++;
    if ({cnt0, cnt1, cnt2, cnt3} !== 26'b0) begin
      bad++; $display("[TB] FAIL reset_cnt: got %h %h %h %h expected 0", cnt0, cnt1, cnt2, cnt3);
    end
    total++;
    if (sats !== 4'b0) begin bad++; $display("[TB] FAIL reset_sat: got %b expected 0000", sats); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_overlap();
    logic [15:0] m0, m1, m2;
    int mism;
    do_reset();
    stream("10101010", "11111111", m0, m1, m2, mism);
    total++;
    if (m0 !== 16'h00A8) begin bad++; $display("[TB] FAIL overlap_mask: got %h expected 00a8", m0); end
    total++;
    if (m1 !== 16'h0088) begin bad++; $display("[TB] FAIL nonoverlap_mask: got %h expected 0088", m1); end
    total++;
    if (cnt0 !== 8'd3) begin bad++; $display("[TB] FAIL overlap_cnt: got %0d expected 3", cnt0); end
    total++;
    if (cnt1 !== 8'd2) begin bad++; $display("[TB] FAIL nonoverlap_cnt: got %0d expected 2", cnt1); end
    total++;
    if (mism !== 0) begin bad++; $display("[TB] FAIL overlap_model: got %0d cycles off expected 0", mism); end
  endtask

  task automatic test_moore();
    logic [15:0] m0, m1, m2;
    int mism;
    do_reset();
    stream("101000", "111100", m0, m1, m2, mism);
    total++;
    if (m2 !== 16'h0010) begin bad++; $display("[TB] FAIL moore_mask: got %h expected 0010", m2); end
    total++;
    if (m0 !== 16'h0008) begin bad++; $display("[TB] FAIL mealy_mask: got %h expected 0008", m0); end
  endtask

  task automatic test_gaps();
    logic [15:0] m0, m1, m2;
    int mism;
    do_reset();
    stream("1000010", "1100011", m0, m1, m2, mism);
    total++;
    if (m0 !== 16'h0040) begin bad++; $display("[TB] FAIL gap_mask: got %h expected 0040", m0); end
    do_reset();
    stream("1100", "1111", m0, m1, m2, mism);
    total++;
    if (m0 !== 16'h0000) begin bad++; $display("[TB] FAIL nomatch_mask: got %h expected 0000", m0); end
  endtask

  task automatic test_reload();
    logic [15:0] m0, m1, m2;
    logic [3:0] e, o;
    int mism;
    do_reset();
    stream("101", "111", m0, m1, m2, mism);
    cycle(1'b0, 1'b1, 1'b1, 4'b1101, 1'b0, e, o);
    total++;
    if (o[0] !== 1'b1) begin bad++; $display("[TB] FAIL load_cycle_hit: got %b expected 1", o[0]); end
    stream("1101101", "1111111", m0, m1, m2, mism);
    total++;
    if (m0 !== 16'h0048) begin bad++; $display("[TB] FAIL reload_mask: got %h expected 0048", m0); end
    total++;
    if (m1 !== 16'h0008) begin bad++; $display("[TB] FAIL reload_novl_mask: got %h expected 0008", m1); end
    total++;
    if (cnt0 !== 8'd3) begin bad++; $display("[TB] FAIL reload_cnt: got %0d expected 3", cnt0); end
  endtask

  task automatic test_saturation();
    logic [15:0] m0, m1, m2;
    logic [3:0] e, o;
    int mism;
    do_reset();
    stream("101010101010", "111111111111", m0, m1, m2, mism);
    total++;
    if (cnt0 !== 8'd5) begin bad++; $display("[TB] FAIL sat_wide_cnt: got %0d expected 5", cnt0); end
    total++;
    if (cnt3 !== 2'd3 || sats[3] !== 1'b1) begin
      bad++; $display("[TB] FAIL sat_narrow: got cnt=%0d sat=%b expected cnt=3 sat=1", cnt3, sats[3]);
    end
    total++;
    if (sats[0] !== 1'b0) begin bad++; $display("[TB] FAIL sat_wide_flag: got %b expected 0", sats[0]); end
    cycle(1'b1, 1'b1, 1'b0, 4'b0, 1'b0, e, o);
    cycle(1'b0, 1'b1, 1'b0, 4'b0, 1'b1, e, o);
    total++;
    if (o[0] !== 1'b1) begin bad++; $display("[TB] FAIL clr_hit_present: got %b expected 1", o[0]); end
    total++;
    if (cnt0 !== 8'd0 || cnt3 !== 2'd0 || sats[3] !== 1'b0) begin
      bad++; $display("[TB] FAIL clr_wins: got %0d %0d sat=%b expected 0 0 sat=0", cnt0, cnt3, sats[3]);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] m0, m1, m2;
    int mism;
    do_reset();
    stream("1010", "1111", m0, m1, m2, mism);
    total++;
    if (outs[2] !== 1'b1 || cnt0 !== 8'd1) begin
      bad++; $display("[TB] FAIL pre_rst: got moore=%b cnt=%0d expected moore=1 cnt=1", outs[2], cnt0);
    end
    in = 1'b1; in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (outs !== 4'b0) begin bad++; $display("[TB] FAIL async_rst_out: got %b expected 0000", outs); end
    total++;
    if ({cnt0, cnt1, cnt2, cnt3} !== 26'b0 || sats !== 4'b0) begin
      bad++; $display("[TB] FAIL async_rst_cnt: got %0d %0d %0d %0d sat=%b expected 0", cnt0, cnt1, cnt2, cnt3, sats);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [3:0] e, o;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
            4'($urandom_range(0, 15)), $urandom_range(0, 29) == 0, e, o);
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL rand_out[%0d]: got %b expected %b", n, o, e); end
      for (int k = 0; k < 4; k++) begin
        total++;
        if (cnt_of(k) !== 8'(mcnt[k])) begin
          bad++; $display("[TB] FAIL rand_cnt%0d[%0d]: got %0d expected %0d", k, n, cnt_of(k), mcnt[k]);
        end
        total++;
        if (sats[k] !== (mcnt[k] == cmax_of(k))) begin
          bad++; $display("[TB] FAIL rand_sat%0d[%0d]: got %b expected %b", k, n, sats[k], mcnt[k] == cmax_of(k));
        end
      end
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    test_reset();
    test_overlap();
    test_moore();
    test_gaps();
    test_reload();
    test_saturation();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
